// File: rtl/conv_mem_host.sv
// Convolution-engine host: image/layer memories, run handshake FSM, watchdog.
// Optional protocol checker (err_cnt port) enabled by CONV_PROTO_CHECK_EN.
module conv_mem_host #(
    parameter int TIMEOUT_CYC = 200000,
    parameter int L1_DEPTH    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        load_en,
    input  logic [11:0] load_addr,
    input  logic [12:0] load_data,
    output logic        ready,
    input  logic        busy,
    input  logic [11:0] iaddr,
    output logic [12:0] idata,
    input  logic        cwr,
    input  logic [11:0] caddr_wr,
    input  logic [12:0] cdata_wr,
    input  logic        crd,
    input  logic [11:0] caddr_rd,
    output logic [12:0] cdata_rd,
    input  logic        csel,
    output logic        done,
    output logic        timeout,
    input  logic        dump_sel,
    input  logic [11:0] dump_addr,
`ifdef CONV_PROTO_CHECK_EN
    output logic [12:0] dump_data,
    output logic [7:0]  err_cnt
`else
    output logic [12:0] dump_data
`endif
);

    localparam int AW1 = $clog2(L1_DEPTH);
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        RUN       = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t         state_q;
    logic           ready_q;
    logic           done_q;
    logic           timeout_q;
    logic [WDW-1:0] wd_q;
    logic [12:0]    dump_q;

    logic [12:0] img_mem [4096];
    logic [12:0] l0_mem  [4096];
    logic [12:0] l1_mem  [L1_DEPTH];

    logic img_we;
    logic l0_we;
    logic l1_we;
    logic in_run;

    assign in_run = (state_q == RUN);
    assign img_we = load_en && ((state_q == IDLE) || (state_q == DONE));
    assign l0_we  = cwr && in_run && !csel;
    assign l1_we  = cwr && in_run && csel;

    // Run handshake and watchdog; all outputs come straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            wd_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= WAIT_BUSY;
                        ready_q   <= 1'b1;
                        timeout_q <= 1'b0;
                        wd_q      <= '0;
                    end
                end
                WAIT_BUSY: begin
                    wd_q <= wd_q + 1'b1;
                    if (wd_q == WD_LAST) begin
                        state_q   <= DONE;
                        ready_q   <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else if (busy) begin
                        state_q <= RUN;
                        ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    wd_q <= wd_q + 1'b1;
                    if (wd_q == WD_LAST) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else if (!busy) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state_q   <= WAIT_BUSY;
                        ready_q   <= 1'b1;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        wd_q      <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Memories are never reset so layer data survives reset and new runs.
    always_ff @(posedge clk) begin
        if (img_we) begin
            img_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (l0_we) begin
            l0_mem[caddr_wr] <= cdata_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (l1_we) begin
            l1_mem[caddr_wr[AW1-1:0]] <= cdata_wr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dump_q <= '0;
        end else if (dump_sel) begin
            dump_q <= l1_mem[dump_addr[AW1-1:0]];
        end else begin
            dump_q <= l0_mem[dump_addr];
        end
    end

    // Reads are asynchronous: a same-cycle write shows up only after the edge.
    always_comb begin
        cdata_rd = '0;
        if (crd) begin
            if (csel) begin
                cdata_rd = l1_mem[caddr_rd[AW1-1:0]];
            end else begin
                cdata_rd = l0_mem[caddr_rd];
            end
        end
    end

    assign idata     = img_mem[iaddr];
    assign ready     = ready_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign dump_data = dump_q;

`ifdef CONV_PROTO_CHECK_EN
    logic [7:0] err_q;
    logic       proto_err;

    assign proto_err = (cwr && crd) ||
                       (cwr && !in_run) ||
                       (csel && cwr && (12'(caddr_wr >> AW1) != 12'd0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= '0;
        end else if (proto_err && (err_q != 8'hFF)) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_cnt = err_q;
`endif

endmodule

// File: doc/conv_mem_host.md
CONV_MEM_HOST -- requirements
Module: conv_mem_host

Interface
REQ-001 Parameter TIMEOUT_CYC, default 200000, SHALL set the maximum cycles allowed in WAIT_BUSY plus RUN before the run is aborted.
REQ-002 Parameter L1_DEPTH, default 1024, SHALL set the layer-1 memory depth; only the low log2(L1_DEPTH) address bits are used.
REQ-003 Ports SHALL be exactly as follows:
- clk  in  1  sole clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that launches a run.
- load_en  in  1  image-memory write strobe.
- load_addr  in  12  image write address.
- load_data  in  13  image write data.
- ready  out  1  run request to the convolution engine.
- busy  in  1  engine busy flag.
- iaddr  in  12  image read address from the engine.
- idata  out  13  image read data.
- cwr  in  1  layer write strobe.
- caddr_wr  in  12  layer write address.
- cdata_wr  in  13  layer write data.
- crd  in  1  layer read enable.
- caddr_rd  in  12  layer read address.
- cdata_rd  out  13  layer read data.
- csel  in  1  layer select: 0 = L0 (4096x13), 1 = L1 (L1_DEPTH x13).
- done  out  1  run finished; held high.
- timeout  out  1  run aborted by the watchdog; held high.
- dump_sel  in  1  dump memory select: 0 = L0, 1 = L1.
- dump_addr  in  12  dump read address.
- dump_data  out  13  registered dump read data.

Function
REQ-004 The block SHALL contain three memories: IMG (4096x13), L0 (4096x13) and L1 (L1_DEPTH x13).
REQ-005 The FSM SHALL have the states IDLE, WAIT_BUSY, RUN and DONE.
REQ-006 FSM transitions SHALL be:
- IDLE -> WAIT_BUSY on start.
- WAIT_BUSY -> RUN when busy=1.
- RUN -> DONE when busy=0.
- DONE -> WAIT_BUSY on start.
REQ-007 ready SHALL be 1 exactly while in WAIT_BUSY; it SHALL drop in the cycle after busy is sampled high.
REQ-008 done SHALL be 1 in DONE and SHALL clear on the edge that leaves DONE.
REQ-009 A start pulse SHALL be ignored in WAIT_BUSY and RUN.
REQ-010 Watchdog:
- A counter SHALL clear on entry to WAIT_BUSY and increment in WAIT_BUSY and RUN.
- When it reaches TIMEOUT_CYC, the FSM SHALL go to DONE with timeout=1.
- timeout SHALL clear on the next start.
REQ-011 A load_en write to IMG SHALL take effect at the clock edge only in IDLE or DONE; it SHALL be ignored in other states.
REQ-012 idata SHALL equal IMG[iaddr] combinationally, with zero-cycle latency, because the engine samples data in the cycle after it registers the address.
REQ-013 cdata_rd SHALL be combinational:
- crd=0 -> 0.
- crd=1, csel=0 -> L0[caddr_rd].
- crd=1, csel=1 -> L1[caddr_rd[9:0]].
REQ-014 When cwr=1 in RUN, the block SHALL write cdata_wr at the clock edge to L0[caddr_wr] (csel=0) or L1[caddr_wr[9:0]] (csel=1); cwr SHALL be ignored in all other states.
REQ-015 A same-cycle write and read to the same address SHALL return the old data on cdata_rd; the new data SHALL be visible from the next cycle.
REQ-016 dump_data SHALL be registered with one-cycle latency: dump_sel=0 -> L0[dump_addr]; dump_sel=1 -> L1[dump_addr[9:0]].
REQ-017 Memories SHALL NOT be cleared by start or by reset; contents persist across runs.

Reset
REQ-018 When reset=0, the block SHALL asynchronously force: state=IDLE, ready=0, done=0, timeout=0, watchdog=0, dump_data=0.
REQ-019 A reset asserted mid-run SHALL return the block to IDLE with ready=0; any partial layer contents SHALL remain in memory.

Configuration
REQ-020 When macro CONV_PROTO_CHECK_EN is defined, the block SHALL add output err_cnt (8 bits, reset 0, saturating at 255).
REQ-021 With CONV_PROTO_CHECK_EN defined, err_cnt SHALL increment once per cycle in which any of these holds:
- cwr=1 and crd=1;
- cwr=1 outside RUN;
- csel=1 and cwr=1 and caddr_wr[11:10] is not 0.
REQ-022 Without CONV_PROTO_CHECK_EN, port err_cnt and all checker logic SHALL be absent, and behaviour SHALL be otherwise identical.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Handshake: load IMG, pulse start, hold busy=0 for 3 cycles, then busy=1 -> ready=1 for those cycles and 0 one cycle after busy is sampled high; busy falls -> done=1 next cycle.
- Image read: IMG[0x041]=0x0ABC, iaddr=0x041 -> idata=0x0ABC in the same cycle.
- Layer write/read: RUN, csel=0, cwr=1, caddr_wr=0x7FF, cdata_wr=0x0123 -> next cycle crd=1, caddr_rd=0x7FF gives cdata_rd=0x0123; csel=1, caddr_wr=0x3FF -> L1[1023] written, then dump_sel=1, dump_addr=0x3FF -> dump_data=value after one cycle.
- Gating: cwr=1 in IDLE -> L0 unchanged; load_en in RUN -> IMG unchanged; with CONV_PROTO_CHECK_EN, err_cnt increments by 1 per offending cycle.
- Watchdog: TIMEOUT_CYC=50, busy held 1 -> DONE with timeout=1 after 50 cycles; next start clears timeout.
- Reset: reset=0 mid-RUN -> ready=0, done=0, state=IDLE immediately; L0 data written before the reset is still readable.
